// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control/memory handshake bundle between mc_ctrl and the datapath.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ins;
    logic             mem_ready;
    logic             memRd;
    logic             memWr;
    logic             iorD;
    logic             irWr;
    logic             pcWr;
    logic             pcWrCond;
    logic [1:0]       pcSrc;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [3:0]       aluCtr;
    logic             extOp;
    logic             regDst;
    logic             memtoReg;
    logic             regWr;
    logic [CNT_W-1:0] retired;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        input  ins, mem_ready,
        output memRd, memWr, iorD, irWr, pcWr, pcWrCond, pcSrc,
        output aluSrcA, aluSrcB, aluCtr, extOp, regDst, memtoReg,
        output regWr, retired, err, err_code
    );

    modport slave (
        output ins, mem_ready,
        input  memRd, memWr, iorD, irWr, pcWr, pcWrCond, pcSrc,
        input  aluSrcA, aluSrcB, aluCtr, extOp, regDst, memtoReg,
        input  regWr, retired, err, err_code
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM over a shared ALU and unified memory.
// Define MCTRL_IMM_EN to add the ADDI/ORI immediate instructions.
module mc_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WRITE,
        S_MEM_WB,
        S_EXEC,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_IMM_EXEC,
        S_IMM_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       memRd;
        logic       memWr;
        logic       iorD;
        logic       pcWr;
        logic       pcWrCond;
        logic [1:0] pcSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluCtr;
        logic       extOp;
        logic       regDst;
        logic       memtoReg;
        logic       regWr;
    } ctl_t;

    state_t          r_state;
    ctl_t            r_ctl;
    logic [CNT_W-1:0] r_retired;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic [TO_W-1:0] r_to_cnt;

    state_t     w_next;
    logic [1:0] w_code;
    logic [5:0] w_op;
    logic [5:0] w_func;
    logic       w_func_ok;
    logic [3:0] w_func_alu;
    logic       w_wait;
    logic       w_timeout;
    logic       w_retire;
    logic       w_fetch_go;
    logic       w_unused;

    assign w_op     = bus.ins[31:26];
    assign w_func   = bus.ins[5:0];
    assign w_unused = ^bus.ins[25:6];

    assign w_wait = (r_state == S_FETCH) ||
                    (r_state == S_MEM_READ) ||
                    (r_state == S_MEM_WRITE);

    // A ready in the same cycle the limit is hit still completes the access.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_wait &&
                       !bus.mem_ready &&
                       (r_to_cnt == TO_W'(MEM_TIMEOUT));

    assign w_retire = (w_next == S_FETCH) &&
                      (r_state != S_FETCH) &&
                      (r_state != S_IDLE);

    assign w_fetch_go = (r_state == S_FETCH) && bus.mem_ready;

    always_comb begin
        w_func_ok  = 1'b1;
        w_func_alu = 4'b0001;
        case (w_func)
            F_ADD:   w_func_alu = 4'b0001;
            F_SUB:   w_func_alu = 4'b1001;
            F_AND:   w_func_alu = 4'b0010;
            F_OR:    w_func_alu = 4'b0011;
            F_SLT:   w_func_alu = 4'b1011;
            default: w_func_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        w_code = 2'b00;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                    w_code = 2'b11;
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_R: begin
                        if (w_func_ok) begin
                            w_next = S_EXEC;
                        end else begin
                            w_next = S_HALT;
                            w_code = 2'b10;
                        end
                    end
                    OP_LW,
                    OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ: w_next = S_BRANCH;
                    OP_J:   w_next = S_JUMP;
`ifdef MCTRL_IMM_EN
                    OP_ADDI,
                    OP_ORI: w_next = S_IMM_EXEC;
`endif
                    default: begin
                        w_next = S_HALT;
                        w_code = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_next = (w_op == OP_SW) ? S_MEM_WRITE
                                         : S_MEM_READ;
            end
            S_MEM_READ: begin
                if (bus.mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                    w_code = 2'b11;
                end
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                    w_code = 2'b11;
                end
            end
            S_EXEC:     w_next = S_R_WB;
            S_IMM_EXEC: w_next = S_IMM_WB;
            S_MEM_WB,
            S_R_WB,
            S_BRANCH,
            S_JUMP,
            S_IMM_WB:   w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    function automatic ctl_t f_ctl(
        state_t     s,
        logic [5:0] op,
        logic [3:0] falu
    );
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memRd   = 1'b1;
                c.aluSrcB = 2'b01;
                c.aluCtr  = 4'b0001;
            end
            S_DECODE: begin
                c.aluSrcB = 2'b11;
                c.aluCtr  = 4'b0001;
                c.extOp   = 1'b1;
            end
            S_MEM_ADDR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                c.aluCtr  = 4'b0001;
                c.extOp   = 1'b1;
            end
            S_MEM_READ: begin
                c.memRd = 1'b1;
                c.iorD  = 1'b1;
            end
            S_MEM_WRITE: begin
                c.memWr = 1'b1;
                c.iorD  = 1'b1;
            end
            S_MEM_WB: begin
                c.regWr    = 1'b1;
                c.memtoReg = 1'b1;
            end
            S_EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluCtr  = falu;
            end
            S_R_WB: begin
                c.regWr  = 1'b1;
                c.regDst = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA  = 1'b1;
                c.aluCtr   = 4'b1001;
                c.pcWrCond = 1'b1;
                c.pcSrc    = 2'b01;
            end
            S_JUMP: begin
                c.pcWr  = 1'b1;
                c.pcSrc = 2'b10;
            end
            S_IMM_EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                if (op == OP_ORI) begin
                    c.aluCtr = 4'b0011;
                    c.extOp  = 1'b0;
                end else if (op == OP_ADDI) begin
                    c.aluCtr = 4'b0001;
                    c.extOp  = 1'b1;
                end
            end
            S_IMM_WB: c.regWr = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ctl      <= '0;
            r_retired  <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_to_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= f_ctl(w_next, w_op, w_func_alu);
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if ((w_next == S_HALT) && (r_state != S_HALT)) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_wait && !bus.mem_ready) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign bus.memRd    = r_ctl.memRd;
    assign bus.memWr    = r_ctl.memWr;
    assign bus.iorD     = r_ctl.iorD;
    assign bus.irWr     = w_fetch_go;
    assign bus.pcWr     = r_ctl.pcWr | w_fetch_go;
    assign bus.pcWrCond = r_ctl.pcWrCond;
    assign bus.pcSrc    = r_ctl.pcSrc;
    assign bus.aluSrcA  = r_ctl.aluSrcA;
    assign bus.aluSrcB  = r_ctl.aluSrcB;
    assign bus.aluCtr   = r_ctl.aluCtr;
    assign bus.extOp    = r_ctl.extOp;
    assign bus.regDst   = r_ctl.regDst;
    assign bus.memtoReg = r_ctl.memtoReg;
    assign bus.regWr    = r_ctl.regWr;
    assign bus.retired  = r_retired;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl with an instruction-level model.
// Runs with MEM_TIMEOUT=3 and a 4-bit retired counter so wrap is reachable.
module tb_mc_ctrl;

    localparam int CW = 4;
    localparam int TO = 3;
`ifdef MCTRL_IMM_EN
    localparam bit IMM = 1'b1;
`else
    localparam bit IMM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(CW)) bus ();

    mc_ctrl #(
        .CNT_W      (CW),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef enum {
        P_ZERO, P_FETCH, P_DECODE, P_MADDR, P_MRD, P_MWR, P_MWB,
        P_EXEC, P_RWB, P_BR, P_JMP, P_IEXEC, P_IWB, P_HALT
    } ph_t;

    typedef struct packed {
        logic       memRd;
        logic       memWr;
        logic       iorD;
        logic       irWr;
        logic       pcWr;
        logic       pcWrCond;
        logic [1:0] pcSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluCtr;
        logic       extOp;
        logic       regDst;
        logic       memtoReg;
        logic       regWr;
    } ctl_t;

    typedef struct {
        string       name;
        logic [25:0] v;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    logic [25:0] act;
    int          n_chk  = 0;
    int          n_fail = 0;

    logic [CW-1:0] m_ret  = '0;
    logic          m_err  = 1'b0;
    logic [1:0]    m_code = 2'b00;
    logic [31:0]   cur_ins = '0;

    // {legal, aluCtr} for an R-type func field
    function automatic logic [4:0] fdec(logic [5:0] f);
        case (f)
            6'b100000: return 5'b1_0001;
            6'b100010: return 5'b1_1001;
            6'b100100: return 5'b1_0010;
            6'b100101: return 5'b1_0011;
            6'b101010: return 5'b1_1011;
            default:   return 5'b0_0000;
        endcase
    endfunction

    function automatic bit legal_op(logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04,
                          6'h02, 6'h08, 6'h0d};
    endfunction

    function automatic ctl_t ctl(ph_t p, logic [31:0] ins, bit mr);
        ctl_t       c;
        logic [4:0] fd;
        c  = '0;
        fd = fdec(ins[5:0]);
        case (p)
            P_FETCH: begin
                c.memRd = 1; c.aluSrcB = 2'b01; c.aluCtr = 4'b0001;
                c.irWr = mr; c.pcWr = mr;
            end
            P_DECODE: begin
                c.aluSrcB = 2'b11; c.aluCtr = 4'b0001; c.extOp = 1;
            end
            P_MADDR: begin
                c.aluSrcA = 1; c.aluSrcB = 2'b10;
                c.aluCtr = 4'b0001; c.extOp = 1;
            end
            P_MRD: begin c.memRd = 1; c.iorD = 1; end
            P_MWR: begin c.memWr = 1; c.iorD = 1; end
            P_MWB: begin c.regWr = 1; c.memtoReg = 1; end
            P_EXEC: begin c.aluSrcA = 1; c.aluCtr = fd[3:0]; end
            P_RWB: begin c.regWr = 1; c.regDst = 1; end
            P_BR: begin
                c.aluSrcA = 1; c.aluCtr = 4'b1001;
                c.pcWrCond = 1; c.pcSrc = 2'b01;
            end
            P_JMP: begin c.pcWr = 1; c.pcSrc = 2'b10; end
            P_IEXEC: begin
                c.aluSrcA = 1; c.aluSrcB = 2'b10;
                if (ins[31:26] == 6'h08) begin
                    c.aluCtr = 4'b0001; c.extOp = 1;
                end else begin
                    c.aluCtr = 4'b0011; c.extOp = 0;
                end
            end
            P_IWB: c.regWr = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic emit(ph_t p, bit mr, bit r = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.mem_ready = mr;
        bus.ins       = (p == P_FETCH) ? $urandom : cur_ins;
        e.name = p.name();
        e.v    = {ctl(p, cur_ins, mr), m_ret, m_err, m_code};
        q.push_back(e);
    endtask

    task automatic do_reset();
        m_ret  = '0;
        m_err  = 1'b0;
        m_code = 2'b00;
        emit(P_ZERO, rb(), 1'b1);
        emit(P_ZERO, rb(), 1'b1);
        emit(P_ZERO, rb(), 1'b0);
    endtask

    task automatic halt(logic [1:0] code);
        m_err  = 1'b1;
        m_code = code;
        repeat (4) emit(P_HALT, rb());
        do_reset();
    endtask

    // k not-ready cycles; more than TO of them times the access out
    task automatic wait_ph(ph_t p, int k, output bit to);
        to = 1'b0;
        for (int i = 0; i < k && i <= TO; i++) emit(p, 1'b0);
        if (k > TO) to = 1'b1;
        else emit(p, 1'b1);
    endtask

    task automatic run_insn(logic [31:0] ins, int fk, int mk);
        bit         to;
        logic [4:0] fd;
        cur_ins = ins;
        fd      = fdec(ins[5:0]);
        wait_ph(P_FETCH, fk, to);
        if (to) begin
            halt(2'b11);
            return;
        end
        emit(P_DECODE, rb());
        case (ins[31:26])
            6'h00: begin
                if (fd[4]) begin
                    emit(P_EXEC, rb());
                    emit(P_RWB, rb());
                    m_ret = m_ret + 1'b1;
                end else begin
                    halt(2'b10);
                end
            end
            6'h23: begin
                emit(P_MADDR, rb());
                wait_ph(P_MRD, mk, to);
                if (to) halt(2'b11);
                else begin
                    emit(P_MWB, rb());
                    m_ret = m_ret + 1'b1;
                end
            end
            6'h2b: begin
                emit(P_MADDR, rb());
                wait_ph(P_MWR, mk, to);
                if (to) halt(2'b11);
                else m_ret = m_ret + 1'b1;
            end
            6'h04: begin
                emit(P_BR, rb());
                m_ret = m_ret + 1'b1;
            end
            6'h02: begin
                emit(P_JMP, rb());
                m_ret = m_ret + 1'b1;
            end
            6'h08, 6'h0d: begin
                if (IMM) begin
                    emit(P_IEXEC, rb());
                    emit(P_IWB, rb());
                    m_ret = m_ret + 1'b1;
                end else begin
                    halt(2'b01);
                end
            end
            default: halt(2'b01);
        endcase
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] x;
        logic [4:0]  fd;
        int          c;
        x = $urandom;
        c = $urandom_range(0, 19);
        if (c < 6) begin
            x[31:26] = 6'h00;
            case ($urandom_range(0, 4))
                0:       x[5:0] = 6'b100000;
                1:       x[5:0] = 6'b100010;
                2:       x[5:0] = 6'b100100;
                3:       x[5:0] = 6'b100101;
                default: x[5:0] = 6'b101010;
            endcase
        end else if (c < 9)  x[31:26] = 6'h23;
        else if (c < 11) x[31:26] = 6'h2b;
        else if (c < 13) x[31:26] = 6'h04;
        else if (c < 15) x[31:26] = 6'h02;
        else if (c == 15) x[31:26] = 6'h08;
        else if (c == 16) x[31:26] = 6'h0d;
        else if (c == 17) begin
            x[31:26] = 6'h00;
            do begin
                x[5:0] = 6'($urandom);
                fd     = fdec(x[5:0]);
            end while (fd[4]);
        end else begin
            do x[31:26] = 6'($urandom);
            while (legal_op(x[31:26]));
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            act = {bus.memRd, bus.memWr, bus.iorD, bus.irWr, bus.pcWr,
                   bus.pcWrCond, bus.pcSrc, bus.aluSrcA, bus.aluSrcB,
                   bus.aluCtr, bus.extOp, bus.regDst, bus.memtoReg,
                   bus.regWr, bus.retired, bus.err, bus.err_code};
            n_chk++;
            if (act !== m_e.v) begin
                n_fail++;
                $display("FAIL %s @%0t: got %h required %h",
                         m_e.name, $time, act, m_e.v);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.ins       = '0;
        bus.mem_ready = 1'b0;

        do_reset();
        run_insn(32'h012A4020, 0, 0);
        run_insn(32'h8D280004, 0, 2);
        run_insn(32'h11090003, 0, 0);
        run_insn(32'h08000010, 0, 0);
        run_insn(32'hAD280008, 1, 3);
        run_insn(32'h3508FFFF, 0, 0);
        run_insn(32'h21080005, 2, 0);
        run_insn(32'hFC000000, 0, 0);
        run_insn(32'h00000007, 0, 0);
        run_insn(32'h08000010, 4, 0);
        run_insn(32'h08000010, 3, 0);
        run_insn(32'h8D280004, 0, 4);
        run_insn(32'hAD280008, 0, 5);

        // reset lands while MEM_WRITE is waiting on memory
        do_reset();
        cur_ins = 32'hAD280008;
        emit(P_FETCH, 1'b1);
        emit(P_DECODE, rb());
        emit(P_MADDR, rb());
        emit(P_MWR, 1'b0);
        do_reset();
        run_insn(32'h08000010, 0, 0);

        for (int i = 0; i < 18; i++) begin
            run_insn(32'h08000010 | 32'($urandom_range(0, 255)),
                     $urandom_range(0, 3), 0);
        end

        for (int i = 0; i < 200; i++) begin
            run_insn(rand_ins(),
                     ($urandom_range(0, 39) == 0) ? 4
                                                  : $urandom_range(0, 3),
                     ($urandom_range(0, 39) == 0) ? 4
                                                  : $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0",
                     q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
